dct_dequant_unzigzag: RTL



---
 rtl/dct_dequant_unzigzag.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dct_dequant_unzigzag.sv
// Dequantizer and un-zigzag stage: multiplies 64 zigzag-ordered coefficients by their
// raster-ordered quantization entries, one per clock, and publishes the raster block at once.
module dct_dequant_unzigzag #(
    parameter int IN_W  = 8,
    parameter int Q_W   = 8,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [64*IN_W-1:0]    data_in,
    input  logic [64*Q_W-1:0]     quantization_table,
    output logic                  busy,
    output logic                  done,
    output logic [64*OUT_W-1:0]   data_out
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Standard JPEG zigzag scan position -> raster position.
    function automatic logic [5:0] zz_map(input logic [5:0] k);
        logic [5:0] r;
        case (k)
            6'd0:  r = 6'd0;  6'd1:  r = 6'd1;  6'd2:  r = 6'd8;  6'd3:  r = 6'd16;
            6'd4:  r = 6'd9;  6'd5:  r = 6'd2;  6'd6:  r = 6'd3;  6'd7:  r = 6'd10;
            6'd8:  r = 6'd17; 6'd9:  r = 6'd24; 6'd10: r = 6'd32; 6'd11: r = 6'd25;
            6'd12: r = 6'd18; 6'd13: r = 6'd11; 6'd14: r = 6'd4;  6'd15: r = 6'd5;
            6'd16: r = 6'd12; 6'd17: r = 6'd19; 6'd18: r = 6'd26; 6'd19: r = 6'd33;
            6'd20: r = 6'd40; 6'd21: r = 6'd48; 6'd22: r = 6'd41; 6'd23: r = 6'd34;
            6'd24: r = 6'd27; 6'd25: r = 6'd20; 6'd26: r = 6'd13; 6'd27: r = 6'd6;
            6'd28: r = 6'd7;  6'd29: r = 6'd14; 6'd30: r = 6'd21; 6'd31: r = 6'd28;
            6'd32: r = 6'd35; 6'd33: r = 6'd42; 6'd34: r = 6'd49; 6'd35: r = 6'd56;
            6'd36: r = 6'd57; 6'd37: r = 6'd50; 6'd38: r = 6'd43; 6'd39: r = 6'd36;
            6'd40: r = 6'd29; 6'd41: r = 6'd22; 6'd42: r = 6'd15; 6'd43: r = 6'd23;
            6'd44: r = 6'd30; 6'd45: r = 6'd37; 6'd46: r = 6'd44; 6'd47: r = 6'd51;
            6'd48: r = 6'd58; 6'd49: r = 6'd59; 6'd50: r = 6'd52; 6'd51: r = 6'd45;
            6'd52: r = 6'd38; 6'd53: r = 6'd31; 6'd54: r = 6'd39; 6'd55: r = 6'd46;
            6'd56: r = 6'd53; 6'd57: r = 6'd60; 6'd58: r = 6'd61; 6'd59: r = 6'd54;
            6'd60: r = 6'd47; 6'd61: r = 6'd55; 6'd62: r = 6'd62; 6'd63: r = 6'd63;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [5:0]             k_q, k_d;
    logic [64*IN_W-1:0]     coef_q, coef_d;
    logic [64*Q_W-1:0]      qt_q, qt_d;
    logic [64*OUT_W-1:0]    buf_q, buf_d;
    logic [64*OUT_W-1:0]    out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [5:0]             r_s;
    logic [IN_W-1:0]        coef_el_s;
    logic [Q_W-1:0]         qt_el_s;
    logic [OUT_W-1:0]       coef_ext_s;
    logic [OUT_W-1:0]       qt_ext_s;
    logic [OUT_W-1:0]       prod_s;

    // The true product always fits in OUT_W signed bits, so an OUT_W-wide multiply
    // of the sign-/zero-extended operands yields the exact result.
    assign r_s        = zz_map(k_q);
    assign coef_el_s  = coef_q[IN_W*int'(k_q) +: IN_W];
    assign qt_el_s    = qt_q[Q_W*int'(r_s) +: Q_W];
    assign coef_ext_s = {{(OUT_W-IN_W){coef_el_s[IN_W-1]}}, coef_el_s};
    assign qt_ext_s   = {{(OUT_W-Q_W){1'b0}}, qt_el_s};
    assign prod_s     = coef_ext_s * qt_ext_s;

    // Next-state and datapath update for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        coef_d  = coef_q;
        qt_d    = qt_q;
        buf_d   = buf_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    coef_d  = data_in;
                    qt_d    = quantization_table;
                    buf_d   = '0;
                    k_d     = 6'd0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                buf_d[OUT_W*int'(r_s) +: OUT_W] = prod_s;
                k_d = k_q + 6'd1;
                if (k_q == 6'd63) begin
                    out_d   = buf_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= 6'd0;
            coef_q  <= '0;
            qt_q    <= '0;
            buf_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            coef_q  <= coef_d;
            qt_q    <= qt_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = out_q;

endmodule
